clock_divider_mc: RTL
=====================

CLOCK_DIVIDER_MC -- requirements
Module: clock_divider_mc

Interface
REQ-001 Parameter N_CH, default 4: number of independent divider channels, range 1..16.
REQ-002 Parameter DIV_W, default 8: width of each channel's divide value.
REQ-003 clk_in  input  1: the block's only clock; all logic is on its rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 en  input  N_CH: per-channel run request.
REQ-006 div  input  N_CH x DIV_W: per-channel divide value D, unsigned.
REQ-007 sync  input  1: single-cycle phase-align request (see Configuration).
REQ-008 clk_out  output  N_CH: registered divided clocks.
REQ-009 tick  output  N_CH: one-cycle pulse in the clk_in cycle in which clk_out[i] rises.
REQ-010 busy  output  N_CH: channel i is running (RUN or DRAIN state).

Function
REQ-011 Each channel is an independent FSM with states IDLE, RUN and DRAIN, and holds a period counter cnt (DIV_W bits) and a latched divide value DL.
REQ-012 Effective divide: DE = 2 when div[i] is 0 or 1; otherwise DE = div[i].
REQ-013 Transition IDLE->RUN when en[i]=1 is sampled at the edge: DL<=DE, cnt<=0, clk_out[i]<=1, tick[i]<=1.
REQ-014 In RUN and DRAIN, clk_out[i]=1 while cnt<ceil(DL/2) and 0 otherwise: odd D gives high for one extra cycle (D=5 gives 3 high, 2 low).
REQ-015 cnt increments each cycle; when cnt==DL-1 it wraps to 0 and the next period begins.
REQ-016 A change to div[i] while running takes effect only at wrap: DL<=DE is sampled at the wrap edge, so no runt or stretched period is produced mid-period.
REQ-017 Deasserting en[i] in RUN causes RUN->DRAIN; the current period completes and the channel goes DRAIN->IDLE at the wrap edge, with clk_out[i] 0 and no tick.
REQ-018 en[i] reasserted during DRAIN causes DRAIN->RUN with no lost or extra period.
REQ-019 tick[i]=1 exactly on the cycles where the registered clk_out[i] transitions 0->1.
REQ-020 In IDLE: clk_out[i]=0, tick[i]=0, busy[i]=0.
REQ-021 Output latency is one clk_in cycle from the en-sampling edge to the first clk_out high.
REQ-022 Channels shall not interact, except through sync.

Reset
REQ-023 While rst=1 at an edge, every channel goes to IDLE with cnt=0, DL=2, clk_out=0, tick=0 and busy=0.
REQ-024 rst asserted mid-period aborts the period immediately, with no drain.
REQ-025 rst has priority over en and sync.
REQ-026 On the first edge after rst deasserts with en[i]=1, the channel enters RUN per REQ-013.

Configuration
REQ-027 Macro CLOCK_DIVIDER_MC_SYNC_EN, when defined: sync=1 at an edge forces every channel in RUN to restart a period (cnt<=0, DL<=DE, clk_out<=1, tick<=1), so all running outputs rise on the same cycle.
REQ-028 With CLOCK_DIVIDER_MC_SYNC_EN defined, sync has no effect on IDLE or DRAIN channels.
REQ-029 With CLOCK_DIVIDER_MC_SYNC_EN defined, sync coincident with a wrap behaves as a wrap.
REQ-030 Without CLOCK_DIVIDER_MC_SYNC_EN, the sync port remains present and is ignored.

Structure
REQ-031 Package clock_divider_pkg holds: the channel state enum (IDLE/RUN/DRAIN), DIV_W_DEFAULT=8, N_CH_DEFAULT=4, and the function computing DE and the high count ceil(DE/2).
REQ-032 Sub-module clock_divider_ch implements one channel; the top instantiates N_CH copies via generate and fans out sync.

Verification
REQ-033 N_CH=2, D0=4, D1=5, en=2'b11: clk_out[0] is 1100 repeating; clk_out[1] is 11100 repeating; tick[1] fires every 5 cycles.
REQ-034 D0 changes 4->2 in the 2nd cycle of a period: that period still lasts 4 cycles, then 10 repeating follows.
REQ-035 D0=8, en[0] dropped at cnt=1: the low phase completes; busy[0] falls and the channel is IDLE after cnt=7; no further tick.
REQ-036 D0=0 and D0=1: both outputs are identical to D=2 (10 repeating).
REQ-037 rst pulsed at cnt=3 of a D=6 period: the next edge shows clk_out=0 and busy=0; with en=1 held, restart occurs one cycle after rst falls.
REQ-038 With CLOCK_DIVIDER_MC_SYNC_EN, D0=4 and D1=6 out of phase, sync pulse: both tick on the following cycle; without the macro, no phase change occurs.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// -----------------------------------------------------------------------------
// clock_divider_pkg
// Shared definitions for the multi-channel clock divider:
//   - ch_state_e     : per-channel FSM state (IDLE / RUN / DRAIN)
//   - DIV_W_DEFAULT  : default width of a channel divide value
//   - N_CH_DEFAULT   : default number of channels
//   - eff_div()      : effective divide DE (0 and 1 are promoted to 2)
//   - high_count()   : number of high cycles in a period, ceil(DE/2)
// -----------------------------------------------------------------------------
package clock_divider_pkg;

  localparam int DIV_W_DEFAULT = 8;
  localparam int N_CH_DEFAULT  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ch_state_e;

  // A divide of 0 or 1 cannot produce a clock, so it behaves as divide-by-2.
  function automatic logic [31:0] eff_div(input logic [31:0] d);
    logic [31:0] de;
    if (d < 32'd2) begin
      de = 32'd2;
    end else begin
      de = d;
    end
    return de;
  endfunction

  // Odd divides spend the extra cycle in the high phase.
  function automatic logic [31:0] high_count(input logic [31:0] de);
    return (de + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clock_divider_ch.sv
// -----------------------------------------------------------------------------
// clock_divider_ch
// One divider channel: IDLE/RUN/DRAIN FSM with a period counter and a divide
// value latched at the start of every period.
// Ports:
//   clk_in  in  : clock (rising edge)
//   rst     in  : synchronous active-high reset
//   en      in  : run request
//   div     in  : divide value D (DIV_W bits, unsigned)
//   sync    in  : restart request for a running channel (already gated by top)
//   clk_out out : registered divided clock
//   tick    out : one-cycle pulse on the cycle clk_out rises
//   busy    out : channel is in RUN or DRAIN
// -----------------------------------------------------------------------------
module clock_divider_ch
  import clock_divider_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] CNT_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DL_RESET = DIV_W'(2);

  ch_state_e        state_r, state_n;
  logic [DIV_W-1:0] cnt_r, cnt_n;
  logic [DIV_W-1:0] dl_r, dl_n;
  logic             clk_r, clk_n;
  logic             tick_r, tick_n;
  logic             busy_r, busy_n;

  logic [DIV_W-1:0] de_s;
  logic [DIV_W-1:0] hi_s;
  logic [DIV_W-1:0] cnt_inc_s;
  logic             wrap_s;

  // Effective divide of the port value, high length of the latched period, wrap detect
  always_comb begin
    de_s      = DIV_W'(eff_div(32'(div)));
    hi_s      = DIV_W'(high_count(32'(dl_r)));
    cnt_inc_s = cnt_r + CNT_ONE;
    wrap_s    = (cnt_r == (dl_r - CNT_ONE));
  end

  // Next-state and next-output decode; outputs describe the cycle after the edge
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    dl_n    = dl_r;
    clk_n   = 1'b0;
    tick_n  = 1'b0;
    case (state_r)
      IDLE: begin
        if (en) begin
          state_n = RUN;
          cnt_n   = CNT_ZERO;
          dl_n    = de_s;
          clk_n   = 1'b1;
          tick_n  = 1'b1;
        end else begin
          state_n = IDLE;
          cnt_n   = CNT_ZERO;
        end
      end
      RUN, DRAIN: begin
        if (wrap_s) begin
          // Period boundary: the only place a new divide value is taken.
          if (en) begin
            state_n = RUN;
            cnt_n   = CNT_ZERO;
            dl_n    = de_s;
            clk_n   = 1'b1;
            tick_n  = 1'b1;
          end else begin
            state_n = IDLE;
            cnt_n   = CNT_ZERO;
          end
        end else if (sync && (state_r == RUN)) begin
          // Phase-align restart; draining channels finish undisturbed.
          state_n = en ? RUN : DRAIN;
          cnt_n   = CNT_ZERO;
          dl_n    = de_s;
          clk_n   = 1'b1;
          tick_n  = 1'b1;
        end else begin
          state_n = en ? RUN : DRAIN;
          cnt_n   = cnt_inc_s;
          clk_n   = (cnt_inc_s < hi_s);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = CNT_ZERO;
        dl_n    = DL_RESET;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and output registers; rst overrides every other input
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      dl_r    <= DL_RESET;
      clk_r   <= 1'b0;
      tick_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      dl_r    <= dl_n;
      clk_r   <= clk_n;
      tick_r  <= tick_n;
      busy_r  <= busy_n;
    end
  end

  assign clk_out = clk_r;
  assign tick    = tick_r;
  assign busy    = busy_r;

endmodule

// File: rtl/clock_divider_mc.sv
// -----------------------------------------------------------------------------
// clock_divider_mc
// N_CH independent clock dividers sharing one input clock.
// Optional feature: define CLOCK_DIVIDER_MC_SYNC_EN to let the sync input
// restart every running channel so their outputs rise together. Without the
// macro the sync port is present but ignored.
// Ports:
//   clk_in  in  1            : clock (rising edge)
//   rst     in  1            : synchronous active-high reset
//   en      in  N_CH         : per-channel run request
//   div     in  N_CH*DIV_W   : per-channel divide value, channel i at [i*DIV_W +: DIV_W]
//   sync    in  1            : single-cycle phase-align request
//   clk_out out N_CH         : registered divided clocks
//   tick    out N_CH         : pulse on the cycle clk_out[i] rises
//   busy    out N_CH         : channel running or draining
// -----------------------------------------------------------------------------
module clock_divider_mc
  import clock_divider_pkg::*;
#(
  parameter int N_CH  = N_CH_DEFAULT,
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH*DIV_W-1:0] div,
  input  logic                  sync,
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       busy
);

  logic sync_s;

`ifdef CLOCK_DIVIDER_MC_SYNC_EN
  assign sync_s = sync;
`else
  logic sync_unused_s;
  assign sync_unused_s = sync;
  assign sync_s        = 1'b0;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clock_divider_ch #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en[i]),
      .div     (div[i*DIV_W +: DIV_W]),
      .sync    (sync_s),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .busy    (busy[i])
    );
  end

endmodule
